ewrapper_link_tx_arbiter: RTL and testbench
===========================================

Name: ewrapper_link_tx_arbiter

Overview:
- Slow-clock-domain transmit scheduler feeding the 72-bit parallel input of the elink TX serializer.
- Arbitrates three emesh requesters: 0 = write, 1 = read request, 2 = read response.
- Frames each accepted 104-bit transaction into two 72-bit beats: 8 data lanes plus 1 frame lane.
- Honours remote link back-pressure, which arrives asynchronously.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, index 0 highest.
- WAIT_SYNC_STAGES, 2: number of flops in the TX_WAIT_IN synchronizer; legal range 2..4.

Ports:
- CLK_IN  input  1  slow (divided) core clock, same clock that drives the serializer's CLK_DIV_IN.
- RESET_N  input  1  asynchronous active-low reset.
- REQ_ACCESS  input  3  per-requester transaction valid.
- REQ_PACKET  input  312  three packets; requester i occupies [104i+103:104i].
- REQ_WAIT  output  3  per-requester stall; a transaction is accepted in a cycle with REQ_ACCESS[i]=1 and REQ_WAIT[i]=0.
- TX_WAIT_IN  input  1  remote link busy, asynchronous.
- TX_DATA_OUT  output  72  to serializer DATA_OUT_FROM_DEVICE; channel k = bits [8k+7:8k], bit 7 serialized first.
- TX_BUSY  output  1  high in BEAT0/BEAT1.
- GRANT_OUT  output  3  one-hot, identifies the requester whose transaction is on TX_DATA_OUT; 0 when idle.

Behaviour:
- Packet fields: [103:72] SRCADDR, [71:40] DATA, [39:8] DSTADDR, [7:4] CTRLMODE, [3:2] DATAMODE, [1] WRITE, [0] reserved.
- Byte stream B0..B15:
  - B0 = {CTRLMODE, DATAMODE, WRITE, 1'b1}; B1 = 0x00.
  - B2..B5 = DSTADDR, MSB first.
  - B6..B9 = DATA, MSB first.
  - B10..B13 = SRCADDR, MSB first.
  - B14, B15 = 0x00.
- Beat0: channel n (0..7) carries Bn; channel 8 (frame) = 0x7F.
- Beat1: channel n carries B(8+n); frame = 0xFF.
- Idle: all 72 bits 0.
- Synchronizer: TX_WAIT_IN passes through WAIT_SYNC_STAGES flops to give wait_s. All stages reset to 1.
- FSM states: IDLE, BEAT0, BEAT1. Reset state IDLE.
  - Accept slot open = (state is IDLE or BEAT1) and wait_s=0.
  - IDLE: on accept -> BEAT0; otherwise stay in IDLE.
  - BEAT0: -> BEAT1 unconditionally. A beat0 is never abandoned, even if wait_s rises.
  - BEAT1: on accept -> BEAT0 (back-to-back, no idle gap); otherwise -> IDLE.
- Arbitration, combinational in the accept cycle:
  - grant = highest-priority i with REQ_ACCESS[i]=1.
  - RR_EN=1: search order starts at last_grant+1 mod 3. last_grant updates only on accept and resets to 2, so index 0 wins first.
  - RR_EN=0: search order is 0, 1, 2.
- REQ_WAIT[i] = ~(slot_open & grant[i]).
  - Combinational from REQ_ACCESS and state.
  - All bits = 1 when slot is closed or during reset.
- Latency and throughput:
  - Accept at edge t: beat0 registered and visible after edge t, beat1 after edge t+1.
  - Maximum throughput: one transaction per 2 cycles.
- Packet capture: the accepted packet is captured in a 104-bit holding register on the accept edge. The requester may change REQ_PACKET afterwards.
- Registered outputs: TX_DATA_OUT, GRANT_OUT and TX_BUSY are all registered.
- Reset values: TX_DATA_OUT = 0, GRANT_OUT = 0, TX_BUSY = 0, REQ_WAIT = 3'b111.
- Reset mid-transaction: outputs clear immediately (asynchronous). The partial transaction is dropped and is not replayed.
- After reset release: no accept until wait_s has propagated a 0, i.e. at least WAIT_SYNC_STAGES cycles with TX_WAIT_IN=0.
- Simultaneous wait_s rise and accept cycle: wait_s is sampled before the accept; if wait_s=1 there is no accept.
- Non-granted requesters must hold REQ_ACCESS and REQ_PACKET stable while stalled (emesh rule). The block does not check this.

Test Plan:
1. Reset, TX_WAIT_IN=0, single write on requester 0 (DSTADDR=0x80800000, DATA=0xDEADBEEF, SRCADDR=0x12345678, CTRLMODE=0, DATAMODE=2, WRITE=1):
   - Beat0 = frame 0x7F, B0..B7 = 0B 00 80 80 00 00 DE AD.
   - Beat1 = frame 0xFF, B8..B15 = BE EF 12 34 56 78 00 00.
   - Then idle all-zero; GRANT_OUT = 3'b001 for both beats.
2. RR_EN=1, all three requesters continuously valid, TX_WAIT_IN=0:
   - Grant order 0,1,2,0,1,2.
   - Frame lane 7F,FF,7F,FF,... with no idle cycles.
   - Each requester sees exactly one REQ_WAIT=0 per 6 cycles.
3. RR_EN=0, requesters 1 and 2 continuously valid:
   - Requester 1 wins every slot; requester 2 REQ_WAIT stays 1.
   - Requester 1 drops -> requester 2 is accepted at the next slot.
4. TX_WAIT_IN asserted in the cycle after beat0:
   - Beat1 still emitted.
   - No new beat0 until WAIT_SYNC_STAGES cycles after TX_WAIT_IN deasserts; REQ_WAIT = 3'b111 meanwhile.
5. RESET_N pulsed low during beat0:
   - TX_DATA_OUT = 0, GRANT_OUT = 0, TX_BUSY = 0 immediately.
   - After release, the dropped transaction is not replayed.
   - First accept occurs no earlier than 2 cycles after release.
6. Requester changes REQ_PACKET on the cycle after acceptance -> the emitted beats reflect the originally captured packet.

Source files
------------

// File: rtl/ewrapper_link_tx_arbiter.sv
// ewrapper_link_tx_arbiter
// Slow-clock transmit scheduler for the elink serializer. Arbitrates the
// write, read-request and read-response emesh requesters. Each accepted
// 104-bit transaction becomes two 72-bit beats: 8 byte lanes plus a frame lane.
module ewrapper_link_tx_arbiter #(
  parameter int RR_EN            = 1,
  parameter int WAIT_SYNC_STAGES = 2
) (
  input  logic         CLK_IN,
  input  logic         RESET_N,
  input  logic [2:0]   REQ_ACCESS,
  input  logic [311:0] REQ_PACKET,
  output logic [2:0]   REQ_WAIT,
  input  logic         TX_WAIT_IN,
  output logic [71:0]  TX_DATA_OUT,
  output logic         TX_BUSY,
  output logic [2:0]   GRANT_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [WAIT_SYNC_STAGES-1:0] wait_sync;
  logic                        wait_s;
  logic                        slot_open;
  logic                        accept;
  logic [1:0]                  last_grant;
  logic [1:0]                  first_idx;
  logic [2:0]                  grant;
  logic [103:1]                sel_packet;
  logic [103:1]                packet_p0;
  logic [71:0]                 data_p1;
  logic [2:0]                  grant_p1;
  logic                        busy_p1;

  // Bit 0 of every packet is reserved and never transmitted.
  logic unused_rsvd;
  assign unused_rsvd = ^{REQ_PACKET[0], REQ_PACKET[104], REQ_PACKET[208]};

  // First beat: control byte, pad, DSTADDR MSB first, upper DATA bytes.
  function automatic logic [71:0] beat0_of(input logic [103:1] pkt);
    logic [7:0] b0;
    b0 = {pkt[7:4], pkt[3:2], pkt[1], 1'b1};
    return {8'h7F, pkt[63:56], pkt[71:64], pkt[15:8], pkt[23:16],
            pkt[31:24], pkt[39:32], 8'h00, b0};
  endfunction

  // Second beat: lower DATA bytes, SRCADDR MSB first, two pad bytes.
  function automatic logic [71:0] beat1_of(input logic [103:1] pkt);
    return {8'hFF, 8'h00, 8'h00, pkt[79:72], pkt[87:80], pkt[95:88],
            pkt[103:96], pkt[47:40], pkt[55:48]};
  endfunction

  // One-hot grant of the first requesting index in the order first, first+1, ...
  function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] first);
    logic [2:0] g;
    g = 3'b000;
    case (first)
      2'd1: begin
        if (req[1])      g = 3'b010;
        else if (req[2]) g = 3'b100;
        else if (req[0]) g = 3'b001;
      end
      2'd2: begin
        if (req[2])      g = 3'b100;
        else if (req[0]) g = 3'b001;
        else if (req[1]) g = 3'b010;
      end
      default: begin
        if (req[0])      g = 3'b001;
        else if (req[1]) g = 3'b010;
        else if (req[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  assign wait_s      = wait_sync[WAIT_SYNC_STAGES-1];
  assign slot_open   = ((state == IDLE) || (state == BEAT1)) && !wait_s;
  assign accept      = slot_open && (|REQ_ACCESS);
  assign REQ_WAIT    = ~({3{slot_open}} & grant);
  assign TX_DATA_OUT = data_p1;
  assign GRANT_OUT   = grant_p1;
  assign TX_BUSY     = busy_p1;

  // Synchronize remote busy; reset to 1 so nothing is sent until a 0 propagates.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) wait_sync <= '1;
    else          wait_sync <= {wait_sync[WAIT_SYNC_STAGES-2:0], TX_WAIT_IN};
  end

  // Search start: one past the last winner in round-robin, else index 0.
  always_comb begin
    first_idx = 2'd0;
    if (RR_EN != 0) begin
      case (last_grant)
        2'd0:    first_idx = 2'd1;
        2'd1:    first_idx = 2'd2;
        default: first_idx = 2'd0;
      endcase
    end
    grant = pick(REQ_ACCESS, first_idx);
  end

  // Route the winning requester's packet to the capture path.
  always_comb begin
    sel_packet = REQ_PACKET[103:1];
    if (grant[1]) sel_packet = REQ_PACKET[207:105];
    if (grant[2]) sel_packet = REQ_PACKET[311:209];
  end

  // Remember the last winner; reset to 2 so requester 0 is served first.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N)    last_grant <= 2'd2;
    else if (accept) last_grant <= grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
  end

  // FSM state register.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state: a beat0 always completes; BEAT1 can chain straight into BEAT0.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BEAT0;
      BEAT0:   state_next = BEAT1;
      BEAT1:   state_next = accept ? BEAT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: hold the accepted packet so the requester is free to move on.
  always_ff @(posedge CLK_IN) begin
    if (accept) packet_p0 <= sel_packet;
  end

  // Stage p1: registered serializer word, grant and busy flag.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      data_p1  <= '0;
      grant_p1 <= '0;
      busy_p1  <= 1'b0;
    end else if (accept) begin
      data_p1  <= beat0_of(sel_packet);
      grant_p1 <= grant;
      busy_p1  <= 1'b1;
    end else if (state == BEAT0) begin
      data_p1  <= beat1_of(packet_p0);
      busy_p1  <= 1'b1;
    end else begin
      data_p1  <= '0;
      grant_p1 <= '0;
      busy_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ewrapper_link_tx_arbiter.sv
// Testbench for ewrapper_link_tx_arbiter: directed scenarios plus a randomized
// run checked against a byte-stream reference model for both arbitration modes.
module tb_ewrapper_link_tx_arbiter;
  localparam int WS = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req_access;
  logic [311:0] req_packet;
  logic         tx_wait;
  logic [2:0]   rr_wait, fp_wait, rr_grant, fp_grant;
  logic [71:0]  rr_data, fp_data;
  logic         rr_busy, fp_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ewrapper_link_tx_arbiter #(.RR_EN(1), .WAIT_SYNC_STAGES(WS)) dut_rr (
    .CLK_IN(clk), .RESET_N(rst_n), .REQ_ACCESS(req_access), .REQ_PACKET(req_packet),
    .REQ_WAIT(rr_wait), .TX_WAIT_IN(tx_wait), .TX_DATA_OUT(rr_data),
    .TX_BUSY(rr_busy), .GRANT_OUT(rr_grant));

  ewrapper_link_tx_arbiter #(.RR_EN(0), .WAIT_SYNC_STAGES(WS)) dut_fp (
    .CLK_IN(clk), .RESET_N(rst_n), .REQ_ACCESS(req_access), .REQ_PACKET(req_packet),
    .REQ_WAIT(fp_wait), .TX_WAIT_IN(tx_wait), .TX_DATA_OUT(fp_data),
    .TX_BUSY(fp_busy), .GRANT_OUT(fp_grant));

  function automatic logic [103:0] mk_pkt(input logic [31:0] src, input logic [31:0] data,
                                          input logic [31:0] dst, input logic [3:0] ctrl,
                                          input logic [1:0] dm, input logic wr);
    return {src, data, dst, ctrl, dm, wr, 1'b0};
  endfunction

  function automatic logic [103:0] rand_pkt();
    return {$urandom, $urandom, $urandom, 8'($urandom)};
  endfunction

  // Reference: build the 16-byte stream, then lay beat `which` onto the lanes.
  function automatic logic [71:0] ref_beat(input logic [103:0] pkt, input int which);
    logic [7:0]  b [16];
    logic [31:0] src, data, dst;
    logic [71:0] r;
    src  = pkt[103:72];
    data = pkt[71:40];
    dst  = pkt[39:8];
    b[0] = {pkt[7:4], pkt[3:2], pkt[1], 1'b1};
    b[1] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      b[2+k]  = 8'(dst  >> (24 - 8*k));
      b[6+k]  = 8'(data >> (24 - 8*k));
      b[10+k] = 8'(src  >> (24 - 8*k));
    end
    b[14] = 8'h00;
    b[15] = 8'h00;
    r = '0;
    for (int n = 0; n < 8; n++) r[8*n +: 8] = b[8*which + n];
    r[71:64] = (which == 0) ? 8'h7F : 8'hFF;
    return r;
  endfunction

  // Reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  int          m_last [2];
  bit          m_b0   [2];
  int          m_win  [2];
  logic [103:0] m_held [2];
  logic [71:0] m_data [2];
  logic [2:0]  m_grant[2];
  logic        m_busy [2];
  bit          m_wq[$];

  task automatic model_init();
    for (int m = 0; m < 2; m++) begin
      m_last[m] = 2; m_b0[m] = 0; m_win[m] = -1; m_held[m] = '0;
      m_data[m] = '0; m_grant[m] = '0; m_busy[m] = 1'b0;
    end
    m_wq = {};
    repeat (WS) m_wq.push_back(1'b0);
  endtask

  task automatic model_eval();
    bit ws;
    int first, idx;
    ws = m_wq[0];
    for (int m = 0; m < 2; m++) begin
      m_win[m] = -1;
      if (!m_b0[m] && !ws) begin
        first = (m == 0) ? (m_last[m] + 1) % 3 : 0;
        for (int k = 0; k < 3; k++) begin
          idx = (first + k) % 3;
          if (m_win[m] < 0 && req_access[idx]) m_win[m] = idx;
        end
      end
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (m_win[m] >= 0) begin
        m_held[m]  = req_packet[104*m_win[m] +: 104];
        m_data[m]  = ref_beat(m_held[m], 0);
        m_grant[m] = 3'b000;
        m_grant[m][m_win[m]] = 1'b1;
        m_busy[m]  = 1'b1;
        m_b0[m]    = 1;
        m_last[m]  = m_win[m];
      end else if (m_b0[m]) begin
        m_data[m] = ref_beat(m_held[m], 1);
        m_busy[m] = 1'b1;
        m_b0[m]   = 0;
      end else begin
        m_data[m] = '0; m_grant[m] = '0; m_busy[m] = 1'b0;
      end
    end
    m_wq.push_back(tx_wait);
    void'(m_wq.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_access = 3'b000; tx_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (WS + 1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_access = 3'b000; tx_wait = 1'b0; req_packet = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rr_data !== 72'h0) begin errors++; $display("FAIL reset_data got %h want 0", rr_data); end
    checks++; if (rr_grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", rr_grant); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rr_busy); end
    checks++; if (rr_wait !== 3'b111) begin errors++; $display("FAIL reset_wait got %b want 111", rr_wait); end
    checks++; if (fp_wait !== 3'b111) begin errors++; $display("FAIL reset_wait_fp got %b want 111", fp_wait); end
  endtask

  task automatic test_single_write();
    logic [2:0] exp_w;
    req_packet[103:0] = mk_pkt(32'h12345678, 32'hDEADBEEF, 32'h80800000, 4'h0, 2'd2, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; req_access = 3'b001;
    for (int j = 0; j < WS + 3; j++) begin
      @(negedge clk);
      exp_w = (j == WS) ? 3'b110 : 3'b111;
      checks++; if (rr_wait !== exp_w) begin errors++; $display("FAIL single_wait j=%0d got %b want %b", j, rr_wait, exp_w); end
      if (j <= WS) begin
        checks++; if (rr_data !== 72'h0) begin errors++; $display("FAIL single_pre_idle j=%0d got %h want 0", j, rr_data); end
      end
      if (j == WS + 1) begin
        checks++; if (rr_data !== 72'h7F_AD_DE_00_00_80_80_00_0B) begin errors++; $display("FAIL single_beat0 got %h want 7fadde000080800000b", rr_data); end
      end
      if (j == WS + 2) begin
        checks++; if (rr_data !== 72'hFF_00_00_78_56_34_12_EF_BE) begin errors++; $display("FAIL single_beat1 got %h want ff0000785634 12efbe", rr_data); end
      end
      if (j > WS) begin
        checks++; if (rr_grant !== 3'b001) begin errors++; $display("FAIL single_grant j=%0d got %b want 001", j, rr_grant); end
        checks++; if (rr_busy !== 1'b1) begin errors++; $display("FAIL single_busy j=%0d got %b want 1", j, rr_busy); end
      end
      @(posedge clk); #1;
      if (j == WS) req_access = 3'b000;
    end
    @(negedge clk);
    checks++; if (rr_data !== 72'h0) begin errors++; $display("FAIL single_idle_data got %h want 0", rr_data); end
    checks++; if (rr_grant !== 3'b000) begin errors++; $display("FAIL single_idle_grant got %b want 000", rr_grant); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", rr_busy); end
  endtask

  task automatic test_round_robin();
    logic [103:0] pk [3];
    logic [2:0]   exp_w, exp_g;
    logic [7:0]   exp_f;
    int           zeros [3];
    int           g;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pk[i] = rand_pkt();
      req_packet[104*i +: 104] = pk[i];
      zeros[i] = 0;
    end
    req_access = 3'b111;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      exp_w = 3'b111;
      if (j % 2 == 0) exp_w[(j/2) % 3] = 1'b0;
      checks++; if (rr_wait !== exp_w) begin errors++; $display("FAIL rr_wait j=%0d got %b want %b", j, rr_wait, exp_w); end
      if (j < 6) for (int i = 0; i < 3; i++) if (rr_wait[i] === 1'b0) zeros[i]++;
      if (j >= 1) begin
        g = ((j - 1) / 2) % 3;
        exp_g = 3'b000; exp_g[g] = 1'b1;
        exp_f = (j % 2 == 1) ? 8'h7F : 8'hFF;
        checks++; if (rr_grant !== exp_g) begin errors++; $display("FAIL rr_grant j=%0d got %b want %b", j, rr_grant, exp_g); end
        checks++; if (rr_data[71:64] !== exp_f) begin errors++; $display("FAIL rr_frame j=%0d got %h want %h", j, rr_data[71:64], exp_f); end
        checks++; if (rr_data !== ref_beat(pk[g], (j % 2 == 1) ? 0 : 1)) begin errors++; $display("FAIL rr_beat j=%0d got %h want %h", j, rr_data, ref_beat(pk[g], (j % 2 == 1) ? 0 : 1)); end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (zeros[i] != 1) begin errors++; $display("FAIL rr_slots req=%0d got %0d want 1", i, zeros[i]); end
    end
    req_access = 3'b000;
  endtask

  task automatic test_fixed_priority();
    logic [2:0] exp_w, exp_g;
    do_reset();
    req_packet = {rand_pkt(), rand_pkt(), rand_pkt()};
    req_access = 3'b110;
    for (int j = 0; j < 10; j++) begin
      if (j == 8) req_access = 3'b100;
      @(negedge clk);
      exp_w = (j % 2 == 1) ? 3'b111 : ((j < 8) ? 3'b101 : 3'b011);
      checks++; if (fp_wait !== exp_w) begin errors++; $display("FAIL fp_wait j=%0d got %b want %b", j, fp_wait, exp_w); end
      if (j >= 1) begin
        exp_g = (j == 9) ? 3'b100 : 3'b010;
        checks++; if (fp_grant !== exp_g) begin errors++; $display("FAIL fp_grant j=%0d got %b want %b", j, fp_grant, exp_g); end
      end
      @(posedge clk); #1;
    end
    req_access = 3'b000;
  endtask

  task automatic test_wait_backpressure();
    logic [2:0] exp_w;
    logic [7:0] exp_f;
    logic       exp_b;
    do_reset();
    req_packet[103:0] = rand_pkt();
    req_access = 3'b001;
    for (int j = 0; j <= 7 + WS; j++) begin
      if (j == 0) tx_wait = 1'b1;
      if (j == 6) tx_wait = 1'b0;
      @(negedge clk);
      exp_w = (j == 0 || j == 6 + WS) ? 3'b110 : 3'b111;
      exp_f = (j == 1 || j == 7 + WS) ? 8'h7F : ((j == 2) ? 8'hFF : 8'h00);
      exp_b = (j == 1 || j == 2 || j == 7 + WS);
      checks++; if (rr_wait !== exp_w) begin errors++; $display("FAIL bp_wait j=%0d got %b want %b", j, rr_wait, exp_w); end
      checks++; if (rr_data[71:64] !== exp_f) begin errors++; $display("FAIL bp_frame j=%0d got %h want %h", j, rr_data[71:64], exp_f); end
      checks++; if (rr_busy !== exp_b) begin errors++; $display("FAIL bp_busy j=%0d got %b want %b", j, rr_busy, exp_b); end
      @(posedge clk); #1;
    end
    req_access = 3'b000;
  endtask

  task automatic test_reset_mid_beat();
    logic [103:0] pa, pb;
    logic [2:0]   exp_w;
    do_reset();
    pa = rand_pkt();
    pb = rand_pkt();
    req_packet[103:0] = pa;
    req_access = 3'b001;
    @(negedge clk);
    checks++; if (rr_wait !== 3'b110) begin errors++; $display("FAIL rst_mid_accept got %b want 110", rr_wait); end
    @(posedge clk); #1;
    req_access = 3'b000;
    checks++; if (rr_data !== ref_beat(pa, 0)) begin errors++; $display("FAIL rst_mid_beat0 got %h want %h", rr_data, ref_beat(pa, 0)); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rr_data !== 72'h0) begin errors++; $display("FAIL rst_mid_data got %h want 0", rr_data); end
    checks++; if (rr_grant !== 3'b000) begin errors++; $display("FAIL rst_mid_grant got %b want 000", rr_grant); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", rr_busy); end
    checks++; if (rr_wait !== 3'b111) begin errors++; $display("FAIL rst_mid_wait got %b want 111", rr_wait); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_packet[103:0] = pb;
    req_access = 3'b001;
    for (int k = 0; k <= WS + 1; k++) begin
      @(negedge clk);
      exp_w = (k == WS) ? 3'b110 : 3'b111;
      checks++; if (rr_wait !== exp_w) begin errors++; $display("FAIL rst_rel_wait k=%0d got %b want %b", k, rr_wait, exp_w); end
      if (k <= WS) begin
        checks++; if (rr_data !== 72'h0) begin errors++; $display("FAIL rst_replay k=%0d got %h want 0", k, rr_data); end
      end else begin
        checks++; if (rr_data !== ref_beat(pb, 0)) begin errors++; $display("FAIL rst_rel_beat0 got %h want %h", rr_data, ref_beat(pb, 0)); end
      end
      @(posedge clk); #1;
      if (k == WS) req_access = 3'b000;
    end
  endtask

  task automatic test_packet_capture();
    logic [103:0] pa, pb;
    do_reset();
    pa = rand_pkt();
    pb = ~pa;
    req_packet[103:0] = pa;
    req_access = 3'b001;
    @(negedge clk);
    checks++; if (rr_wait !== 3'b110) begin errors++; $display("FAIL cap_accept got %b want 110", rr_wait); end
    @(posedge clk); #1;
    req_packet[103:0] = pb;
    req_access = 3'b000;
    @(negedge clk);
    checks++; if (rr_data !== ref_beat(pa, 0)) begin errors++; $display("FAIL cap_beat0 got %h want %h", rr_data, ref_beat(pa, 0)); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rr_data !== ref_beat(pa, 1)) begin errors++; $display("FAIL cap_beat1 got %h want %h", rr_data, ref_beat(pa, 1)); end
    checks++; if (fp_data !== ref_beat(pa, 1)) begin errors++; $display("FAIL cap_beat1_fp got %h want %h", fp_data, ref_beat(pa, 1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  exp_w, act_w, act_g;
    logic [71:0] act_d;
    logic        act_b;
    do_reset();
    model_init();
    for (int c = 0; c < 400; c++) begin
      req_access = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 3) == 0) req_packet[104*i +: 104] = rand_pkt();
      tx_wait = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      model_eval();
      for (int m = 0; m < 2; m++) begin
        act_d = (m == 0) ? rr_data  : fp_data;
        act_g = (m == 0) ? rr_grant : fp_grant;
        act_b = (m == 0) ? rr_busy  : fp_busy;
        act_w = (m == 0) ? rr_wait  : fp_wait;
        exp_w = 3'b111;
        if (m_win[m] >= 0) exp_w[m_win[m]] = 1'b0;
        checks++; if (act_d !== m_data[m]) begin errors++; $display("FAIL rand_data dut=%0d c=%0d got %h want %h", m, c, act_d, m_data[m]); end
        checks++; if (act_g !== m_grant[m]) begin errors++; $display("FAIL rand_grant dut=%0d c=%0d got %b want %b", m, c, act_g, m_grant[m]); end
        checks++; if (act_b !== m_busy[m]) begin errors++; $display("FAIL rand_busy dut=%0d c=%0d got %b want %b", m, c, act_b, m_busy[m]); end
        checks++; if (act_w !== exp_w) begin errors++; $display("FAIL rand_wait dut=%0d c=%0d got %b want %b", m, c, act_w, exp_w); end
      end
      model_edge();
      @(posedge clk); #1;
    end
    req_access = 3'b000;
    tx_wait = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_wait_backpressure();
    test_reset_mid_beat();
    test_packet_capture();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
